enemy_swarm: RTL and testbench
==============================

# enemy_swarm

Multi-channel enemy motion controller for the barrage game. It drives up to N enemies along diagonal trajectories from a shared movement tick and spawns them one at a time at the right screen edge with a random Y. Each enemy retires on a bullet hit or on reaching the left edge, and all enemies reset to the spawn column on player crash. It sits between the random generator / collision logic and the VGA sprite renderer, and replaces the single-enemy movers.

## Interface
- N_ENEMY, 4, number of enemy channels
- COORD_W, 12, coordinate width
- TICK_DIV, 1000000, clk cycles per movement tick
- SPAWN_GAP, 64, ticks between successive spawns
- X_SPAWN, 1180, spawn/parking X
- X_MIN, 30, left escape bound
- Y_MIN, 20, top bound
- Y_MAX, 700, bottom bound / wrap target
- DX, 3, X step per tick
- DY, 5, Y step per tick
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- crash  in  1  player crash; level
- randint  in  10  random Y source, zero-extended
- hit  in  N_ENEMY  per-channel kill pulse from collision logic
- enemy_x  out  N_ENEMY*COORD_W  X per channel; channel i at [i*COORD_W +: COORD_W]
- enemy_y  out  N_ENEMY*COORD_W  Y per channel, same packing
- active  out  N_ENEMY  channel visible
- escape  out  N_ENEMY  one-cycle pulse when a channel exits at X_MIN
- tick  out  1  one-cycle movement strobe

## Operation
- Prescaler counts 0..TICK_DIV-1. tick is registered high for one cycle when the count wraps. The prescaler holds while crash=1.
- Each channel has two states, IDLE and ACTIVE. IDLE parks at x=X_SPAWN with y unchanged.
- Spawner counts ticks to SPAWN_GAP-1.
  - At that count, the lowest-index IDLE channel becomes ACTIVE with x=X_SPAWN and y=clamp(randint, Y_MIN+1, Y_MAX). The spawn counter then returns to 0.
  - If no channel is IDLE, the spawn counter saturates at SPAWN_GAP-1 and the spawn occurs on the first cycle a channel is IDLE.
- When an ACTIVE channel sees tick:
  - If x <= X_MIN+DX: go to IDLE, set x=X_SPAWN, pulse escape[i]. This compare is done before subtracting, so there is no underflow.
  - Otherwise x -= DX.
  - Y: if y <= Y_MIN+DY then y=Y_MAX, else y -= DY.
- Per-channel priority in a cycle: crash > hit[i] > tick.
  - crash=1: every channel goes IDLE with x=X_SPAWN. The spawn counter clears to 0. No escape pulses.
  - hit[i] on an ACTIVE channel: go IDLE, x=X_SPAWN. A tick in the same cycle is ignored for that channel. hit on an IDLE channel is ignored.
- Reset values: enemy_x=X_SPAWN and enemy_y=Y_MAX for every channel; active=0, escape=0, tick=0; prescaler and spawn counter at 0.
- rst mid-operation returns to the reset state immediately. Work in flight is not preserved.

## Timing
- All outputs are registered.
- Positions, active and escape update on the clock edge where tick=1. They are therefore visible one cycle after the tick pulse.
- A spawn takes effect on the same edge as the triggering tick.
- After crash deasserts, the first tick comes TICK_DIV cycles later.
- Latency from hit to active=0 is one clock.

## Configuration
- ENEMY_BOUNCE_EN defined:
  - Each channel has a direction bit, loaded from randint[0] at spawn (1 = up).
  - Up: if y <= Y_MIN+DY, flip direction and leave y unchanged that tick; otherwise y -= DY.
  - Down: if y >= Y_MAX-DY, flip direction and leave y unchanged; otherwise y += DY.
- ENEMY_BOUNCE_EN undefined: wrap-to-Y_MAX behaviour as described in Operation; no direction state.

## Structure
- Package enemy_pkg holds the channel state enum (IDLE, ACTIVE), the coordinate type of COORD_W bits, and the default bound and step constants.
- Sub-module enemy_channel holds one channel's state, position, hit/escape handling and (under ENEMY_BOUNCE_EN) the direction bit.
- The top level instantiates N_ENEMY copies of enemy_channel and contains the prescaler, the spawner and the priority encoder for IDLE channels.

## Test plan
Bench parameters: TICK_DIV=4, SPAWN_GAP=2, N_ENEMY=4.
- Reset state: assert rst mid-run -> enemy_x=1180, enemy_y=700, active=0, tick=0 on all channels, without waiting for a clock edge.
- Spawn and move: randint=350 -> after 2 ticks channel 0 is active at (1180,350); next tick (1177,345); channel 1 spawns 2 ticks after channel 0.
- Clamping: randint=5 -> spawn y=21; randint=1000 -> spawn y=700.
- Boundaries: y=24 at tick -> y=700; x=32 at tick -> active[0]=0, one escape[0] pulse, x=1180.
- Contention: crash and hit[1] on the same cycle as tick -> all channels IDLE, no escape pulses, prescaler frozen while crash is high; hit on an IDLE channel -> no change.
- Full swarm: all 4 channels ACTIVE -> spawn counter holds at 1; hit[2] -> channel 2 respawns on the next cycle. With ENEMY_BOUNCE_EN, y=24 moving up -> direction flips, y stays 24, next tick y=29.

Source files
------------

// File: rtl/enemy_pkg.sv
// enemy_pkg: shared channel state, coordinate type and default bounds/steps for the enemy swarm
package enemy_pkg;
    typedef enum logic {IDLE, ACTIVE} state_t;
    localparam int DEF_COORD_W   = 12;
    typedef logic [DEF_COORD_W-1:0] coord_t;
    localparam int DEF_N_ENEMY   = 4;
    localparam int DEF_TICK_DIV  = 1000000;
    localparam int DEF_SPAWN_GAP = 64;
    localparam int DEF_X_SPAWN   = 1180;
    localparam int DEF_X_MIN     = 30;
    localparam int DEF_Y_MIN     = 20;
    localparam int DEF_Y_MAX     = 700;
    localparam int DEF_DX        = 3;
    localparam int DEF_DY        = 5;
endpackage

// File: rtl/enemy_channel.sv
// enemy_channel: one enemy's state, position, hit/escape handling and optional bounce direction
// Ports: clk, rst (async, active-high); tick movement strobe; crash (all park); hit kill pulse;
//        spawn/spawn_y load a new enemy; spawn_dir initial direction (ENEMY_BOUNCE_EN only);
//        x, y position; active visible; escape one-cycle pulse on leaving at the left edge.
// Build option: ENEMY_BOUNCE_EN selects bounce between Y bounds instead of wrapping to Y_MAX.
module enemy_channel import enemy_pkg::*; #(
    parameter int W       = DEF_COORD_W,
    parameter int X_SPAWN = DEF_X_SPAWN,
    parameter int X_MIN   = DEF_X_MIN,
    parameter int Y_MIN   = DEF_Y_MIN,
    parameter int Y_MAX   = DEF_Y_MAX,
    parameter int DX      = DEF_DX,
    parameter int DY      = DEF_DY
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         crash,
    input  logic         hit,
    input  logic         spawn,
    input  logic [W-1:0] spawn_y,
`ifdef ENEMY_BOUNCE_EN
    input  logic         spawn_dir,
`endif
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         active,
    output logic         escape
);
    localparam logic [W-1:0] XS    = W'(X_SPAWN);
    localparam logic [W-1:0] YM    = W'(Y_MAX);
    localparam logic [W-1:0] X_LIM = W'(X_MIN + DX);
    localparam logic [W-1:0] Y_LO  = W'(Y_MIN + DY);
    localparam logic [W-1:0] DXW   = W'(DX);
    localparam logic [W-1:0] DYW   = W'(DY);
    state_t       st;
    logic [W-1:0] y_step;
    assign active = st == ACTIVE;
`ifdef ENEMY_BOUNCE_EN
    localparam logic [W-1:0] Y_HI = W'(Y_MAX - DY);
    logic up, flip;
    // at a bound the tick only reverses direction; y moves again on the following tick
    assign flip   = up ? y <= Y_LO : y >= Y_HI;
    assign y_step = flip ? y : up ? y - DYW : y + DYW;
`else
    assign y_step = y <= Y_LO ? YM : y - DYW;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= IDLE;
            x      <= XS;
            y      <= YM;
            escape <= 1'b0;
`ifdef ENEMY_BOUNCE_EN
            up     <= 1'b0;
`endif
        end else begin
            escape <= 1'b0;
            if (crash) begin
                st <= IDLE;
                x  <= XS;
            end else if (st == ACTIVE) begin
                if (hit) begin
                    st <= IDLE;
                    x  <= XS;
                end else if (tick) begin
                    y <= y_step;
`ifdef ENEMY_BOUNCE_EN
                    if (flip) up <= ~up;
`endif
                    // compare before subtracting so x never underflows
                    if (x <= X_LIM) begin
                        st     <= IDLE;
                        x      <= XS;
                        escape <= 1'b1;
                    end else begin
                        x <= x - DXW;
                    end
                end
            end else if (spawn) begin
                st <= ACTIVE;
                x  <= XS;
                y  <= spawn_y;
`ifdef ENEMY_BOUNCE_EN
                up <= spawn_dir;
`endif
            end
        end
    end
endmodule

// File: rtl/enemy_swarm.sv
// enemy_swarm: multi-channel enemy motion controller with shared tick prescaler and spawner
// Ports: clk, rst (async, active-high); crash player crash level; randint random spawn Y;
//        hit per-channel kill pulses; enemy_x/enemy_y packed positions (channel i at
//        [i*COORD_W +: COORD_W]); active per-channel visible; escape per-channel exit pulse;
//        tick one-cycle movement strobe.
// Build option: ENEMY_BOUNCE_EN enables per-channel bounce direction loaded from randint[0].
module enemy_swarm import enemy_pkg::*; #(
    parameter int N_ENEMY   = DEF_N_ENEMY,
    parameter int COORD_W   = DEF_COORD_W,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int SPAWN_GAP = DEF_SPAWN_GAP,
    parameter int X_SPAWN   = DEF_X_SPAWN,
    parameter int X_MIN     = DEF_X_MIN,
    parameter int Y_MIN     = DEF_Y_MIN,
    parameter int Y_MAX     = DEF_Y_MAX,
    parameter int DX        = DEF_DX,
    parameter int DY        = DEF_DY
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         crash,
    input  logic [9:0]                   randint,
    input  logic [N_ENEMY-1:0]           hit,
    output logic [N_ENEMY*COORD_W-1:0]   enemy_x,
    output logic [N_ENEMY*COORD_W-1:0]   enemy_y,
    output logic [N_ENEMY-1:0]           active,
    output logic [N_ENEMY-1:0]           escape,
    output logic                         tick
);
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int SW = $clog2(SPAWN_GAP + 1);
    localparam logic [COORD_W-1:0] Y_FLOOR = COORD_W'(Y_MIN + 1);
    localparam logic [COORD_W-1:0] Y_CEIL  = COORD_W'(Y_MAX);
    logic [PW-1:0]      pcnt;
    logic [SW-1:0]      scnt;
    logic               pend, wrap, at_gap, go;
    logic [N_ENEMY-1:0] idle, sel;
    logic [COORD_W-1:0] ry, spawn_y;
    assign wrap = pcnt == PW'(TICK_DIV - 1);
    // prescaler is held at zero during crash so the first tick after release is a full period away
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else begin
            tick <= !crash && wrap;
            pcnt <= (crash || wrap) ? '0 : pcnt + PW'(1);
        end
    end
    assign idle    = ~active;
    // isolate the lowest set bit: lowest-index idle channel
    assign sel     = idle & (~idle + N_ENEMY'(1));
    assign ry      = COORD_W'(randint);
    assign spawn_y = ry < Y_FLOOR ? Y_FLOOR : ry > Y_CEIL ? Y_CEIL : ry;
    assign at_gap  = scnt == SW'(SPAWN_GAP - 1);
    // pend marks a gap that already elapsed while the swarm was full; spawn then needs no tick
    assign go      = !crash && at_gap && |idle && (tick || pend);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt <= '0;
            pend <= 1'b0;
        end else if (crash || go) begin
            scnt <= '0;
            pend <= 1'b0;
        end else if (tick) begin
            if (at_gap) pend <= 1'b1;
            else scnt <= scnt + SW'(1);
        end
    end
    for (genvar i = 0; i < N_ENEMY; i++) begin : g_ch
        enemy_channel #(
            .W(COORD_W), .X_SPAWN(X_SPAWN), .X_MIN(X_MIN), .Y_MIN(Y_MIN),
            .Y_MAX(Y_MAX), .DX(DX), .DY(DY)
        ) u_ch (
            .clk(clk),
            .rst(rst),
            .tick(tick),
            .crash(crash),
            .hit(hit[i]),
            .spawn(go && sel[i]),
            .spawn_y(spawn_y),
`ifdef ENEMY_BOUNCE_EN
            .spawn_dir(randint[0]),
`endif
            .x(enemy_x[i*COORD_W +: COORD_W]),
            .y(enemy_y[i*COORD_W +: COORD_W]),
            .active(active[i]),
            .escape(escape[i])
        );
    end
endmodule

// File: tb/tb_enemy_swarm.sv
// tb_enemy_swarm: randomized self-checking bench for enemy_swarm against a behavioural model
module tb_enemy_swarm;
    localparam int N  = 4;
    localparam int W  = 12;
    localparam int TD = 4;
    localparam int SG = 2;
    logic           clk = 1'b0;
    logic           rst, crash;
    logic [9:0]     randint;
    logic [N-1:0]   hit;
    logic [N*W-1:0] enemy_x, enemy_y;
    logic [N-1:0]   active, escape;
    logic           tick;
    int n_cmp = 0, n_bad = 0;
    int mx[N], my[N];
    bit ma[N], mesc[N], mdir[N];
    bit mtick;
    int cyc, ticks;

    enemy_swarm #(.N_ENEMY(N), .COORD_W(W), .TICK_DIV(TD), .SPAWN_GAP(SG)) dut (
        .clk(clk), .rst(rst), .crash(crash), .randint(randint), .hit(hit),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .active(active), .escape(escape), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = 1180; my[i] = 700; ma[i] = 0; mesc[i] = 0; mdir[i] = 0;
        end
        mtick = 0; cyc = 0; ticks = 0;
    endtask

    // predicts the state after the coming clock edge from the inputs now applied
    task automatic model_step();
        int sel = -1;
        int sy;
        bit sp;
        for (int i = 0; i < N; i++) if (!ma[i] && sel < 0) sel = i;
        // a spawn is due once SPAWN_GAP ticks have been seen since the last spawn
        sp = !crash && sel >= 0 && ((mtick && ticks + 1 >= SG) || ticks >= SG);
        sy = randint < 21 ? 21 : randint > 700 ? 700 : int'(randint);
        for (int i = 0; i < N; i++) begin
            mesc[i] = 0;
            if (crash) begin
                ma[i] = 0; mx[i] = 1180;
            end else if (ma[i]) begin
                if (hit[i]) begin
                    ma[i] = 0; mx[i] = 1180;
                end else if (mtick) begin
`ifdef ENEMY_BOUNCE_EN
                    if (mdir[i]) begin
                        if (my[i] <= 25) mdir[i] = 0; else my[i] -= 5;
                    end else begin
                        if (my[i] >= 695) mdir[i] = 1; else my[i] += 5;
                    end
`else
                    my[i] = my[i] <= 25 ? 700 : my[i] - 5;
`endif
                    if (mx[i] <= 33) begin
                        ma[i] = 0; mx[i] = 1180; mesc[i] = 1;
                    end else mx[i] -= 3;
                end
            end else if (sp && i == sel) begin
                ma[i] = 1; mx[i] = 1180; my[i] = sy; mdir[i] = randint[0];
            end
        end
        ticks = (crash || sp) ? 0 : ticks + int'(mtick);
        mtick = !crash && (cyc + 1) % TD == 0;
        cyc = crash ? 0 : cyc + 1;
    endtask

    task automatic compare_all();
        logic [N*W-1:0] ex, ey;
        logic [N-1:0] ea, ee;
        for (int i = 0; i < N; i++) begin
            ex[i*W +: W] = W'(mx[i]);
            ey[i*W +: W] = W'(my[i]);
            ea[i] = ma[i];
            ee[i] = mesc[i];
        end
        check("enemy_x", enemy_x, ex);
        check("enemy_y", enemy_y, ey);
        check("active", active, ea);
        check("escape", escape, ee);
        check("tick", tick, mtick);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 0; crash = 0; hit = '0; randint = '0;
        model_reset();
        model_step();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_x"}, enemy_x, {N{12'd1180}});
        check({tag, "_y"}, enemy_y, {N{12'd700}});
        check({tag, "_active"}, active, '0);
        check({tag, "_escape"}, escape, '0);
        check({tag, "_tick"}, tick, 1'b0);
    endtask

    // ri < 0 selects boundary-biased random Y; crash/hit rates are 1-in-N per cycle (0 = never)
    task automatic run(input int cycles, input int ri, input int crash_rate, input int hit_rate);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            compare_all();
            if (ri >= 0) randint = 10'(ri);
            else begin
                case ($urandom_range(0, 7))
                    0: randint = 10'd5;
                    1: randint = 10'd1000;
                    2: randint = 10'd20;
                    3: randint = 10'd21;
                    4: randint = 10'd700;
                    5: randint = 10'd701;
                    default: randint = 10'($urandom);
                endcase
            end
            crash = crash_rate > 0 && $urandom_range(0, crash_rate - 1) == 0;
            for (int i = 0; i < N; i++) hit[i] = hit_rate > 0 && $urandom_range(0, hit_rate - 1) == 0;
            model_step();
        end
    endtask

    initial begin
        rst = 1; crash = 0; hit = '0; randint = '0;
        #1;
        check_reset_values("reset");
        release_reset();
        run(12, 350, 0, 0);
        check("spawn0_active", active[0], 1'b1);
        check("spawn0_x", enemy_x[W-1:0], 12'd1180);
        check("spawn0_y", enemy_y[W-1:0], 12'd350);
        run(2200, -1, 0, 0);
        run(3000, -1, 40, 12);
        @(negedge clk);
        #2 rst = 1;
        #1 check_reset_values("midrun_reset");
        release_reset();
        run(400, -1, 60, 10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
